// File: rtl/hex_sr_ctrl.sv
// Slot-addressed access controller for a recirculating 6-bit hex shift register.
// Tracks the slot at the register head and serves READ, WRITE and CLEAR commands.
module hex_sr_ctrl #(
  parameter int LENGTH = 62,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [5:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [5:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              sr_recirc,
  output logic [5:0]        sr_din,
  input  logic [5:0]        sr_dout,
  output logic [ADDR_W-1:0] pos
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] CLR  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LENGTH - 1);
  // One bit wider so LENGTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   LEN_EXT = (ADDR_W + 1)'(LENGTH);

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        wdata_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept;
  logic              addr_ok;
  logic              hit;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign addr_ok   = ({1'b0, cmd_addr} < LEN_EXT);
  assign hit       = (state == WAIT) && (pos == addr_q);
  assign rsp_valid = (state == RESP);

  // Loads happen only in the write access cycle and throughout CLR; reset forces rotation.
  always_comb begin
    sr_recirc = 1'b1;
    sr_din    = 6'd0;
    if (!rst) begin
      if (state == CLR) begin
        sr_recirc = 1'b0;
      end else if (hit && (op_q == OP_WRITE)) begin
        sr_recirc = 1'b0;
        sr_din    = wdata_q;
      end
    end
  end

  // The register shifts every clock, so the head slot index never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (pos == LAST) begin
      pos <= '0;
    end else begin
      pos <= pos + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      wdata_q   <= 6'd0;
      clr_cnt   <= '0;
      rsp_rdata <= 6'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            clr_cnt   <= '0;
            rsp_rdata <= 6'd0;
            rsp_err   <= 1'b0;
            case (cmd_op)
              OP_READ, OP_WRITE: begin
                if (addr_ok) begin
                  state <= WAIT;
                end else begin
                  rsp_err <= 1'b1;
                  state   <= RESP;
                end
              end
              OP_CLEAR: state <= CLR;
              default:  state <= RESP;
            endcase
          end
        end
        WAIT: begin
          if (pos == addr_q) begin
            if (op_q == OP_READ) begin
              rsp_rdata <= sr_dout;
            end
            state <= RESP;
          end
        end
        CLR: begin
          if (clr_cnt == LAST) begin
            state <= RESP;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_rdata <= 6'd0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_sr_ctrl.sv
// Randomized self-checking bench for hex_sr_ctrl, with a behavioural shift register
// and a slot-indexed reference memory.
module tb_hex_sr_ctrl;

  localparam int L  = 62;
  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [5:0]    cmd_wdata;
  logic          rsp_valid;
  logic [5:0]    rsp_rdata;
  logic          rsp_err;
  logic          sr_recirc;
  logic [5:0]    sr_din;
  logic [5:0]    sr_dout;
  logic [AW-1:0] pos;

  hex_sr_ctrl #(.LENGTH(L), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sr_recirc (sr_recirc),
    .sr_din    (sr_din),
    .sr_dout   (sr_dout),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical register: sreg[0] is the head driven onto sr_dout.
  logic [5:0] sreg [L];
  assign sr_dout = sreg[0];

  // Reference: contents by slot number, plus the slot number expected at the head.
  logic [5:0] ref_mem [L];
  int         exp_pos;
  bit         synced;
  int         n_checks;
  int         n_fail;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock: rotate/load the physical register, then advance or re-anchor slot numbering.
  task automatic step();
    logic       was_rst;
    logic       rec;
    logic [5:0] din;
    logic [5:0] head;
    logic [5:0] tmp [L];
    #2;
    was_rst = rst;
    rec     = sr_recirc;
    din     = sr_din;
    @(posedge clk);
    #1;
    head = sreg[0];
    for (int i = 0; i < L - 1; i++) sreg[i] = sreg[i + 1];
    sreg[L-1] = rec ? head : din;
    if (was_rst) begin
      for (int i = 0; i < L; i++) tmp[i] = ref_mem[(exp_pos + 1 + i) % L];
      ref_mem = tmp;
      exp_pos = 0;
      synced  = 1'b1;
    end else begin
      exp_pos = (exp_pos + 1) % L;
    end
    if (synced) checkOutput("pos", pos, exp_pos);
  endtask

  task automatic idleCycles(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checkOutput("idle_recirc", sr_recirc, 1);
      checkOutput("idle_din", sr_din, 0);
      checkOutput("idle_rsp_valid", rsp_valid, 0);
      checkOutput("idle_ready", cmd_ready, 1);
      step();
    end
  endtask

  task automatic junkCmd();
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_addr  = AW'($urandom_range(0, 63));
    cmd_wdata = 6'($urandom_range(0, 63));
  endtask

  task automatic abortWithReset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abort_recirc", sr_recirc, 1);
    step();
    step();
    rst = 1'b0;
    checkOutput("abort_pos0", pos, 0);
    idleCycles(L + 10);
  endtask

  // Issue one command; wait_pos >= 0 aligns the accept edge with that head slot,
  // abort_at > 0 asserts reset in that busy cycle instead of completing.
  task automatic applyStimulus(input int op, input int addr, input int wdata,
                               input int wait_pos, input int abort_at);
    int p;
    int lat;
    bit ok;
    bit rw;
    if (wait_pos >= 0) begin
      cmd_valid = 1'b0;
      while (exp_pos != wait_pos) idleCycles(1);
    end
    checkOutput("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_addr  = AW'(addr);
    cmd_wdata = 6'(wdata);
    p  = exp_pos;
    ok = (addr < L);
    rw = (op == 1) || (op == 2);
    step();
    junkCmd();
    if (rw && ok) begin
      lat = ((addr - p - 1 + 2 * L) % L) + 1;
      for (int k = 1; k <= lat; k++) begin
        if (k == abort_at) begin
          abortWithReset();
          return;
        end
        checkOutput("wait_ready", cmd_ready, 0);
        checkOutput("wait_rsp_valid", rsp_valid, 0);
        if (op == 2 && k == lat) begin
          checkOutput("wr_recirc", sr_recirc, 0);
          checkOutput("wr_din", sr_din, wdata);
          checkOutput("wr_pos", pos, addr);
          ref_mem[addr] = 6'(wdata);
        end else begin
          checkOutput("wait_recirc", sr_recirc, 1);
        end
        step();
        junkCmd();
      end
    end else if (op == 3) begin
      for (int k = 1; k <= L; k++) begin
        if (k == abort_at) begin
          abortWithReset();
          return;
        end
        checkOutput("clr_recirc", sr_recirc, 0);
        checkOutput("clr_din", sr_din, 0);
        checkOutput("clr_ready", cmd_ready, 0);
        ref_mem[exp_pos] = 6'd0;
        step();
        junkCmd();
      end
    end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_err", rsp_err, (rw && !ok) ? 1 : 0);
    checkOutput("rsp_rdata", rsp_rdata, (op == 1 && ok) ? ref_mem[addr] : 0);
    checkOutput("rsp_ready", cmd_ready, 0);
    checkOutput("rsp_recirc", sr_recirc, 1);
    cmd_valid = 1'b0;
    step();
    checkOutput("post_rsp_valid", rsp_valid, 0);
    checkOutput("post_rdata", rsp_rdata, 0);
    checkOutput("post_err", rsp_err, 0);
    checkOutput("post_ready", cmd_ready, 1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_pos   = 0;
    synced    = 1'b0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = 6'd0;
    for (int i = 0; i < L; i++) begin
      sreg[i]    = 6'($urandom_range(0, 63));
      ref_mem[i] = sreg[i];
    end
    step();
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_pos", pos, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rdata", rsp_rdata, 0);
    checkOutput("reset_err", rsp_err, 0);
    checkOutput("reset_recirc", sr_recirc, 1);
    checkOutput("reset_din", sr_din, 0);
    checkOutput("reset_ready", cmd_ready, 1);

    $display("[TB] idle rotation");
    idleCycles(130);

    $display("[TB] clear then read");
    applyStimulus(3, 0, 0, -1, 0);
    applyStimulus(1, 17, 0, -1, 0);

    $display("[TB] write/read slot 5");
    applyStimulus(2, 5, 6'h2A, -1, 0);
    applyStimulus(1, 5, 0, -1, 0);
    applyStimulus(1, 4, 0, -1, 0);
    applyStimulus(1, 6, 0, -1, 0);

    $display("[TB] latency boundaries");
    applyStimulus(2, 10, 6'h13, -1, 0);
    applyStimulus(1, 10, 0, 10, 0);
    applyStimulus(1, 10, 0, 9, 0);
    applyStimulus(1, 0, 0, L - 1, 0);

    $display("[TB] out-of-range addresses");
    applyStimulus(1, 62, 0, -1, 0);
    applyStimulus(1, 63, 0, -1, 0);
    applyStimulus(2, 63, 6'h3F, -1, 0);
    applyStimulus(0, 0, 0, -1, 0);

    $display("[TB] random commands");
    for (int n = 0; n < 40; n++) begin
      int op;
      int wp;
      op = $urandom_range(0, 9);
      op = (op < 4) ? 2 : (op < 8) ? 1 : (op == 8) ? 0 : (($urandom_range(0, 3) == 0) ? 3 : 1);
      wp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : -1;
      applyStimulus(op, $urandom_range(0, 63), $urandom_range(0, 63), wp, 0);
    end

    $display("[TB] reset during write wait");
    for (int n = 0; n < 8; n++) applyStimulus(2, $urandom_range(0, L - 1), $urandom_range(1, 63), -1, 0);
    applyStimulus(2, 30, 6'h15, 30, 5);
    for (int a = 0; a < L; a += 3) applyStimulus(1, a, 0, -1, 0);

    $display("[TB] reset during clear");
    for (int n = 0; n < 8; n++) applyStimulus(2, $urandom_range(0, L - 1), $urandom_range(1, 63), -1, 0);
    applyStimulus(3, 0, 0, -1, 20);
    for (int a = 0; a < L; a++) applyStimulus(1, a, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
